vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 159 +++++++++++++++
 tb/tb_vga_timing.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, phase FSMs and registered sync/blank strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic          pixel_clk,
  input  logic          reset,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          DISPLAY,
  output logic [XW-1:0] X,
  output logic [YW-1:0] Y,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic [15:0]   FRAME_CNT
);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  localparam logic [XW-1:0] H_FRONT_AT = XW'(H_DISPLAY);
  localparam logic [XW-1:0] H_SYNC_AT  = XW'(H_DISPLAY + H_FP);
  localparam logic [XW-1:0] H_BACK_AT  = XW'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);

  localparam logic [YW-1:0] V_FRONT_AT = YW'(V_DISPLAY);
  localparam logic [YW-1:0] V_SYNC_AT  = YW'(V_DISPLAY + V_FP);
  localparam logic [YW-1:0] V_BACK_AT  = YW'(V_DISPLAY + V_FP + V_SYNC);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          run_q;
  phase_e        h_ph_q, h_ph_d;
  phase_e        v_ph_q, v_ph_d;
  logic          hsync_q, vsync_q, display_q;
  logic          line_start_q, frame_start_q;
  logic          line_start_d, frame_start_d;

  // run_q holds the raster at the origin for the first cycle after reset so
  // that cycle presents X=0/Y=0 with its start strobes.
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (run_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
        y_d = y_q;
      end
    end
  end

  always_comb begin
    h_ph_d = h_ph_q;
    unique case (h_ph_q)
      PH_ACTIVE: if (x_d == H_FRONT_AT) h_ph_d = PH_FRONT;
      PH_FRONT:  if (x_d == H_SYNC_AT)  h_ph_d = PH_SYNC;
      PH_SYNC:   if (x_d == H_BACK_AT)  h_ph_d = PH_BACK;
      PH_BACK:   if (x_d == '0)         h_ph_d = PH_ACTIVE;
      default:                          h_ph_d = PH_ACTIVE;
    endcase
  end

  always_comb begin
    v_ph_d = v_ph_q;
    unique case (v_ph_q)
      PH_ACTIVE: if (y_d == V_FRONT_AT) v_ph_d = PH_FRONT;
      PH_FRONT:  if (y_d == V_SYNC_AT)  v_ph_d = PH_SYNC;
      PH_SYNC:   if (y_d == V_BACK_AT)  v_ph_d = PH_BACK;
      PH_BACK:   if (y_d == '0)         v_ph_d = PH_ACTIVE;
      default:                          v_ph_d = PH_ACTIVE;
    endcase
  end

  assign line_start_d  = (x_d == '0);
  assign frame_start_d = (x_d == '0) && (y_d == '0);

  // Strobes are decoded from the next-state position so they land in the
  // same register stage as X/Y and carry no skew against them.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      run_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      h_ph_q        <= PH_ACTIVE;
      v_ph_q        <= PH_ACTIVE;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      display_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      x_q           <= x_d;
      y_q           <= y_d;
      h_ph_q        <= h_ph_d;
      v_ph_q        <= v_ph_d;
      hsync_q       <= (h_ph_d == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      vsync_q       <= (v_ph_d == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      display_q     <= (h_ph_d == PH_ACTIVE) && (v_ph_d == PH_ACTIVE);
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        first_frame_q;

  // The first frame after reset is frame 0; later frame starts advance the count.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      first_frame_q <= 1'b1;
    end else if (frame_start_d) begin
      if (first_frame_q) begin
        first_frame_q <= 1'b0;
      end else begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign FRAME_CNT = frame_cnt_q;
`else
  assign FRAME_CNT = '0;
`endif

  assign X           = x_q;
  assign Y           = y_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DISPLAY     = display_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 640x480, an 800-wide positive-sync line, and a tiny raster for whole-frame checks.
// Expectations are queued with the tick they apply to; a negedge monitor pops and compares them.
module tb_vga_timing;

  localparam int T0 = 3;  // last tick with reset asserted; cycle k after release is tick T0+k
  localparam int RT = T0 + 1902;  // tick presenting the mid-frame reset values

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tick = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  logic [9:0]  a_x, a_y;
  logic        a_hs, a_vs, a_de, a_ls, a_fs;
  logic [15:0] a_fc;
  logic [10:0] b_x;
  logic [9:0]  b_y;
  logic        b_hs, b_vs, b_de, b_ls, b_fs;
  logic [15:0] b_fc;
  logic [3:0]  c_x, c_y;
  logic        c_hs, c_vs, c_de, c_ls, c_fs;
  logic [15:0] c_fc;

  vga_timing dut_a (
    .pixel_clk(clk), .reset(rst), .HSYNC(a_hs), .VSYNC(a_vs), .DISPLAY(a_de),
    .X(a_x), .Y(a_y), .LINE_START(a_ls), .FRAME_START(a_fs), .FRAME_CNT(a_fc)
  );

  vga_timing #(
    .H_DISPLAY(800), .H_FP(40), .H_SYNC(128), .H_BP(88), .SYNC_POL(1)
  ) dut_b (
    .pixel_clk(clk), .reset(rst), .HSYNC(b_hs), .VSYNC(b_vs), .DISPLAY(b_de),
    .X(b_x), .Y(b_y), .LINE_START(b_ls), .FRAME_START(b_fs), .FRAME_CNT(b_fc)
  );

  vga_timing #(
    .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_DISPLAY(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_c (
    .pixel_clk(clk), .reset(rst), .HSYNC(c_hs), .VSYNC(c_vs), .DISPLAY(c_de),
    .X(c_x), .Y(c_y), .LINE_START(c_ls), .FRAME_START(c_fs), .FRAME_CNT(c_fc)
  );

  typedef struct {
    int    t;
    int    sig;
    int    val;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Running measurements taken from cycle 1 onward.
  int a_hs_low = 0, b_hs_high = 0, c_vs_low = 0, c_de_cnt = 0;
  int c_last_fs = 0, c_period = 0;

  task automatic ex(input int t, input int sig, input int val, input string nm);
    exp_t e;
    e.t = t; e.sig = sig; e.val = val; e.nm = nm;
    sb.push_back(e);
  endtask

  function automatic int sample(input int sig);
    case (sig)
      0:  return int'(a_x);
      1:  return int'(a_y);
      2:  return int'(a_de);
      3:  return int'(a_hs);
      4:  return int'(a_vs);
      5:  return int'(a_ls);
      6:  return int'(a_fs);
      7:  return int'(a_fc);
      8:  return a_hs_low;
      10: return int'(b_x);
      11: return int'(b_y);
      12: return int'(b_de);
      13: return int'(b_hs);
      14: return int'(b_vs);
      16: return int'(b_fs);
      18: return b_hs_high;
      20: return int'(c_x);
      21: return int'(c_y);
      22: return int'(c_de);
      23: return int'(c_hs);
      24: return int'(c_vs);
      25: return int'(c_ls);
      26: return int'(c_fs);
      27: return int'(c_fc);
      28: return c_vs_low;
      29: return c_de_cnt;
      30: return c_period;
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    int act;
    if (tick > T0) begin
      if (a_hs == 1'b0) a_hs_low++;
      if (b_hs == 1'b1) b_hs_high++;
      if (c_vs == 1'b0) c_vs_low++;
      if (c_de == 1'b1) c_de_cnt++;
      if (c_fs == 1'b1) begin
        c_period  = tick - c_last_fs;
        c_last_fs = tick;
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].t == tick) begin
        act = sample(sb[i].sig);
        n_tests++;
        if (act != sb[i].val) begin
          n_fail++;
          $display("FAIL %s @tick %0d: got %0d, expected %0d", sb[i].nm, tick, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic goto(input int n);
    while (tick < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int fc1, fc2, fcw;
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc1 = 1; fc2 = 2; fcw = 16'hFFFF;
`else
    fc1 = 0; fc2 = 0; fcw = 0;
`endif
    // Reset state (tick 2, reset held).
    ex(2, 0, 0, "rst_a_x"); ex(2, 1, 0, "rst_a_y"); ex(2, 2, 0, "rst_a_de");
    ex(2, 3, 1, "rst_a_hs"); ex(2, 4, 1, "rst_a_vs"); ex(2, 5, 0, "rst_a_ls");
    ex(2, 6, 0, "rst_a_fs"); ex(2, 7, 0, "rst_a_fc");
    ex(2, 13, 0, "rst_b_hs"); ex(2, 14, 0, "rst_b_vs"); ex(2, 12, 0, "rst_b_de");
    ex(2, 27, 0, "rst_c_fc");
    // Default raster, first line.
    ex(T0+1, 0, 0, "a_c1_x"); ex(T0+1, 1, 0, "a_c1_y"); ex(T0+1, 2, 1, "a_c1_de");
    ex(T0+1, 3, 1, "a_c1_hs"); ex(T0+1, 4, 1, "a_c1_vs"); ex(T0+1, 5, 1, "a_c1_ls");
    ex(T0+1, 6, 1, "a_c1_fs"); ex(T0+1, 7, 0, "a_c1_fc");
    ex(T0+2, 0, 1, "a_c2_x"); ex(T0+2, 5, 0, "a_c2_ls"); ex(T0+2, 6, 0, "a_c2_fs");
    ex(T0+640, 2, 1, "a_x639_de"); ex(T0+641, 0, 640, "a_x640"); ex(T0+641, 2, 0, "a_x640_de");
    ex(T0+656, 3, 1, "a_x655_hs"); ex(T0+657, 3, 0, "a_x656_hs");
    ex(T0+752, 3, 0, "a_x751_hs"); ex(T0+753, 3, 1, "a_x752_hs");
    ex(T0+800, 0, 799, "a_x799"); ex(T0+800, 8, 96, "a_hs_low_line");
    ex(T0+801, 0, 0, "a_l1_x"); ex(T0+801, 1, 1, "a_l1_y"); ex(T0+801, 5, 1, "a_l1_ls");
    ex(T0+801, 6, 0, "a_l1_fs"); ex(T0+801, 2, 1, "a_l1_de");
    // Wide positive-sync raster.
    ex(T0+1, 13, 0, "b_c1_hs"); ex(T0+1, 14, 0, "b_c1_vs"); ex(T0+1, 16, 1, "b_c1_fs");
    ex(T0+800, 12, 1, "b_x799_de"); ex(T0+801, 12, 0, "b_x800_de");
    ex(T0+840, 13, 0, "b_x839_hs"); ex(T0+841, 13, 1, "b_x840_hs");
    ex(T0+968, 13, 1, "b_x967_hs"); ex(T0+969, 13, 0, "b_x968_hs");
    ex(T0+1056, 10, 1055, "b_x1055"); ex(T0+1056, 18, 128, "b_hs_high_line");
    ex(T0+1057, 10, 0, "b_l1_x"); ex(T0+1057, 11, 1, "b_l1_y");
    // Tiny raster: 16x12 totals, 192-cycle frame.
    ex(T0+1, 26, 1, "c_c1_fs"); ex(T0+1, 22, 1, "c_c1_de"); ex(T0+2, 26, 0, "c_c2_fs");
    ex(T0+10, 23, 1, "c_x9_hs"); ex(T0+11, 23, 0, "c_x10_hs");
    ex(T0+13, 23, 0, "c_x12_hs"); ex(T0+14, 23, 1, "c_x13_hs");
    ex(T0+88, 22, 1, "c_y5x7_de"); ex(T0+89, 22, 0, "c_y5x8_de");
    ex(T0+97, 21, 6, "c_y6"); ex(T0+97, 22, 0, "c_y6x0_de"); ex(T0+97, 25, 1, "c_y6_ls");
    ex(T0+128, 24, 1, "c_y7_vs"); ex(T0+129, 21, 8, "c_y8"); ex(T0+129, 24, 0, "c_y8_vs");
    ex(T0+160, 24, 0, "c_y9_vs"); ex(T0+161, 24, 1, "c_y10_vs");
    ex(T0+192, 28, 32, "c_vs_low_frame"); ex(T0+192, 29, 48, "c_de_frame");
    ex(T0+193, 20, 0, "c_f1_x"); ex(T0+193, 21, 0, "c_f1_y"); ex(T0+193, 26, 1, "c_f1_fs");
    ex(T0+193, 30, 192, "c_frame_period");
    ex(T0+1, 27, 0, "c_fc_f0"); ex(T0+193, 27, fc1, "c_fc_f1"); ex(T0+385, 27, fc2, "c_fc_f2");
    ex(T0+576, 27, fcw, "c_fc_preload"); ex(T0+577, 27, 0, "c_fc_wrap");
    // Mid-frame reset on the default raster at X=300, Y=2.
    ex(RT-1, 0, 300, "a_pre_x"); ex(RT-1, 1, 2, "a_pre_y");
    ex(RT, 0, 0, "a_mr_x"); ex(RT, 1, 0, "a_mr_y"); ex(RT, 2, 0, "a_mr_de");
    ex(RT, 3, 1, "a_mr_hs"); ex(RT, 5, 0, "a_mr_ls"); ex(RT, 6, 0, "a_mr_fs");
    ex(RT, 27, 0, "c_mr_fc");
    ex(RT+1, 0, 0, "a_rs_x"); ex(RT+1, 1, 0, "a_rs_y"); ex(RT+1, 2, 1, "a_rs_de");
    ex(RT+1, 5, 1, "a_rs_ls"); ex(RT+1, 6, 1, "a_rs_fs");
    ex(RT+1, 16, 1, "b_rs_fs"); ex(RT+1, 26, 1, "c_rs_fs");

    goto(T0);
    rst = 1'b0;
    goto(T0 + 1);
    n_tests++;
    if (a_x != 10'd0) begin
      n_fail++;
      $display("FAIL d_c1_x: got %0d, expected 0", a_x);
    end
    n_tests++;
    if (a_fs != 1'b1) begin
      n_fail++;
      $display("FAIL d_c1_fs: got %0d, expected 1", a_fs);
    end
    n_tests++;
    if (a_de != 1'b1) begin
      n_fail++;
      $display("FAIL d_c1_de: got %0d, expected 1", a_de);
    end
    goto(T0 + 450);
`ifdef VGA_TIMING_FRAME_CNT_EN
    force dut_c.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_c.frame_cnt_q;
`endif
    goto(RT - 1);
    rst = 1'b1;
    goto(RT);
    rst = 1'b0;
    goto(RT + 1);
    n_tests++;
    if (a_x != 10'd0 || a_y != 10'd0) begin
      n_fail++;
      $display("FAIL d_rs_xy: got %0d/%0d, expected 0/0", a_x, a_y);
    end
    n_tests++;
    if (a_fs != 1'b1) begin
      n_fail++;
      $display("FAIL d_rs_fs: got %0d, expected 1", a_fs);
    end
    goto(RT + 8);
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s never sampled: got none, expected %0d @tick %0d", sb[i].nm, sb[i].val, sb[i].t);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
